gb_pulse_channel_param: RTL and testbench
=========================================

// Module: gb_pulse_channel_param
// PURPOSE
//  Parametrised Game Boy APU square/pulse channel; one instance per pulse voice (CH1 with sweep, CH2 without).
//  Produces a registered digital level from frequency, duty, length, envelope and optional sweep units.
//  Adds sweep-overflow disable, DAC-off gating, a shadow-frequency output and configurable timer/field widths.
// PARAMETERS
//  FREQ_W          11  frequency register width; period = (2^FREQ_W - freq) * TIMER_PRESCALE clk cycles per duty step
//  LEN_W           6   length field width; note lasts 2^LEN_W - length length ticks
//  VOL_W           4   volume/level width
//  ENV_W           3   envelope pace width
//  SWEEP_W         3   sweep pace and shift width
//  HAS_SWEEP       1   1 = sweep unit present; 0 = freq_shadow tracks frequency every cycle
//  TIMER_PRESCALE  4   clk cycles per frequency-timer count
// PORTS
//  clk                  in   1        system clock, all state on posedge
//  reset                in   1        asynchronous, active-low reset
//  clk_length_ctr       in   1        1-cycle enable: length tick
//  clk_vol_env          in   1        1-cycle enable: envelope tick
//  clk_sweep            in   1        1-cycle enable: sweep tick
//  sweep_time           in   SWEEP_W  sweep pace; 0 = sweep off (timer reloads as 2^SWEEP_W)
//  sweep_decreasing     in   1        1 = subtract, 0 = add
//  num_sweep_shifts     in   SWEEP_W  sweep shift amount
//  wave_duty            in   2        duty select
//  length               in   LEN_W    length load value
//  initial_volume       in   VOL_W    volume loaded on trigger
//  envelope_increasing  in   1        envelope direction
//  num_envelope_sweeps  in   ENV_W    envelope pace; 0 = envelope frozen
//  start                in   1        1-cycle trigger
//  single               in   1        1 = length counter enabled
//  frequency            in   FREQ_W   frequency register
//  level                out  VOL_W    channel output level
//  enable               out  1        channel active
//  freq_shadow          out  FREQ_W   current (swept) frequency
// BEHAVIOUR
//  Reset (async, reset=0): enable=0, level=0, freq_shadow=0, volume=0, duty_step=0, all timers/counters=0.
//  Trigger (start=1): enable = dac_on = (initial_volume!=0 | envelope_increasing); len_remain = 2^LEN_W-length
//   (LEN_W+1 bits); volume=initial_volume; env_timer=num_envelope_sweeps; freq_shadow=frequency;
//   freq_timer reloaded; sweep_timer=sweep_time (0->2^SWEEP_W); duty_step NOT reset. If HAS_SWEEP & shift!=0 &
//   !decreasing & overflow (see sweep) -> enable=0 same edge.
//  Priority: start beats every tick in the same cycle; reset beats everything, any time.
//  dac_on=0 at any time forces enable=0 next edge.
//  Freq timer: runs only while enable; decrements each clk; on reaching 0 reloads (2^FREQ_W-freq_shadow)*PRESCALE-1,
//   duty_step = (duty_step+1) mod 8.
//  Duty table, step0..7: 00=00000001 01=10000001 10=10000111 11=01111110; duty_out = table[wave_duty][duty_step].
//  level registered: enable & duty_out ? volume : 0 (1-cycle latency from duty_step/volume).
//  Length: on clk_length_ctr, if single & len_remain!=0: decrement; reaching 0 -> enable=0. single=0: no change.
//  Envelope: on clk_vol_env, if pace!=0: env_timer--; at 0 reload pace and step volume +/-1, saturating at
//   2^VOL_W-1 / 0; saturation does not clear enable.
//  Sweep (HAS_SWEEP): on clk_sweep, sweep_timer--; at 0 reload; if sweep_time!=0: new = shadow +/- (shadow>>shift)
//   computed FREQ_W+1 bits; add & new>2^FREQ_W-1 -> enable=0, shadow unchanged; else if shift!=0 shadow=new.
//   Subtract never underflows.
//  Ticks while enable=0 are ignored except length (still counts, cannot re-enable).
// STRUCTURE
//  gb_apu_pkg: duty_t enum, DUTY_TABLE[4][8] constant, shared tick-priority helpers.
//  Sub-module gb_vol_envelope (timer + saturating volume), reusable by noise channel.
//  Top holds frequency timer, duty sequencer, length, sweep, enable logic.
// TESTING
//  1 Reset low mid-note (enable=1, level=7) -> enable=0, level=0 before next clk edge; stays 0 until trigger.
//  2 length=62, single=1, trigger, 2 length ticks -> enable falls on 2nd tick; single=0 -> enable=1 after 100 ticks.
//  3 vol=1, inc, pace=1: 20 env ticks -> level peaks 15, no wrap; vol=15 dec: 15 ticks -> 0, enable stays 1.
//  4 freq=0x7FF, duty=10, vol=15: duty_step advances every 4 clk; level sequence 15,0,0,0,0,15,15,15.
//  5 freq=0x700, inc, shift=1, pace=1 -> enable=0 at trigger; freq=0x7FF dec shift=7 -> freq_shadow=0x7F0 after tick.
//  6 vol=0 dec trigger -> enable stays 0; start with clk_length_ctr at len_remain=1 -> start wins, len_remain reloads.

Source files
------------

// File: rtl/gb_pulse_channel_param_pkg.sv
// Shared definitions for the Game Boy APU voices: duty waveform table and tick qualifiers.
// Pure combinational helpers; no state, no backpressure.
package gb_pulse_channel_param_pkg;

  typedef enum logic [1:0] {
    DUTY_12 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_50 = 2'b10,
    DUTY_75 = 2'b11
  } duty_t;

  // Row index is the duty code; bit 7 of each row is sequencer step 0.
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b0111_1110,
    8'b1000_0111,
    8'b1000_0001,
    8'b0000_0001
  };

  function automatic logic duty_bit(input duty_t duty, input logic [2:0] step);
    logic [7:0] row;
    row = DUTY_TABLE[duty];
    return row[3'd7 - step];
  endfunction

  // A trigger in the same cycle always swallows the frame-sequencer tick.
  function automatic logic tick_live(input logic tick, input logic start, input logic active);
    return tick & ~start & active;
  endfunction

  function automatic logic tick_free(input logic tick, input logic start);
    return tick & ~start;
  endfunction

endpackage

// File: rtl/gb_pulse_channel_param_env.sv
// Volume envelope: pace timer plus saturating up/down volume; volume changes on the tick edge.
// No backpressure; load (trigger) takes priority over tick.
module gb_vol_envelope
  import gb_pulse_channel_param_pkg::*;
#(
  parameter int VOL_W = 4,
  parameter int ENV_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             tick,
  input  logic [VOL_W-1:0] initial_volume,
  input  logic             increasing,
  input  logic [ENV_W-1:0] pace,
  output logic [VOL_W-1:0] volume
);

  logic [ENV_W-1:0] env_timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      volume    <= '0;
      env_timer <= '0;
    end else if (load) begin
      volume    <= initial_volume;
      env_timer <= pace;
    end else if (tick && (pace != '0)) begin
      // A timer left at 0 (pace raised after trigger) expires on the first tick.
      if (env_timer <= ENV_W'(1)) begin
        env_timer <= pace;
        if (increasing && (volume != '1)) begin
          volume <= volume + VOL_W'(1);
        end else if (!increasing && (volume != '0)) begin
          volume <= volume - VOL_W'(1);
        end
      end else begin
        env_timer <= env_timer - ENV_W'(1);
      end
    end
  end

endmodule

// File: rtl/gb_pulse_channel_param.sv
// Game Boy pulse voice: frequency timer, duty sequencer, length, optional sweep; level is registered (1 clk).
// No backpressure; trigger beats all ticks in the same cycle, reset beats everything.
module gb_pulse_channel_param
  import gb_pulse_channel_param_pkg::*;
#(
  parameter int FREQ_W         = 11,
  parameter int LEN_W          = 6,
  parameter int VOL_W          = 4,
  parameter int ENV_W          = 3,
  parameter int SWEEP_W        = 3,
  parameter int HAS_SWEEP      = 1,
  parameter int TIMER_PRESCALE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_length_ctr,
  input  logic               clk_vol_env,
  input  logic               clk_sweep,
  input  logic [SWEEP_W-1:0] sweep_time,
  input  logic               sweep_decreasing,
  input  logic [SWEEP_W-1:0] num_sweep_shifts,
  input  logic [1:0]         wave_duty,
  input  logic [LEN_W-1:0]   length,
  input  logic [VOL_W-1:0]   initial_volume,
  input  logic               envelope_increasing,
  input  logic [ENV_W-1:0]   num_envelope_sweeps,
  input  logic               start,
  input  logic               single,
  input  logic [FREQ_W-1:0]  frequency,
  output logic [VOL_W-1:0]   level,
  output logic               enable,
  output logic [FREQ_W-1:0]  freq_shadow
);

  localparam int TMR_W = FREQ_W + $clog2(TIMER_PRESCALE) + 1;
  localparam int LR_W  = LEN_W + 1;
  localparam int SW1_W = SWEEP_W + 1;

  function automatic logic [TMR_W-1:0] period_of(input logic [FREQ_W-1:0] f);
    logic [TMR_W-1:0] steps;
    steps = TMR_W'(2**FREQ_W) - TMR_W'(f);
    return steps * TMR_W'(TIMER_PRESCALE) - TMR_W'(1);
  endfunction

  logic             dac_on;
  logic             env_tick;
  logic             sweep_tick;
  logic             len_tick;
  logic             len_expire;
  logic             sweep_ovf;
  logic             trig_ovf;
  logic             enable_nxt;
  logic [TMR_W-1:0] freq_timer;
  logic [2:0]       duty_step;
  logic [LR_W-1:0]  len_remain;
  logic [VOL_W-1:0] volume;

  assign dac_on     = (initial_volume != '0) | envelope_increasing;
  assign env_tick   = tick_live(clk_vol_env, start, enable);
  assign sweep_tick = tick_live(clk_sweep, start, enable);
  assign len_tick   = tick_free(clk_length_ctr, start);
  assign len_expire = len_tick & single & (len_remain == LR_W'(1));

  gb_vol_envelope #(
    .VOL_W (VOL_W),
    .ENV_W (ENV_W)
  ) u_env (
    .clk            (clk),
    .reset          (reset),
    .load           (start),
    .tick           (env_tick),
    .initial_volume (initial_volume),
    .increasing     (envelope_increasing),
    .pace           (num_envelope_sweeps),
    .volume         (volume)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_remain <= '0;
    end else if (start) begin
      len_remain <= LR_W'(2**LEN_W) - LR_W'(length);
    end else if (len_tick && single && (len_remain != '0)) begin
      len_remain <= len_remain - LR_W'(1);
    end
  end

  // duty_step deliberately survives a trigger; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_timer <= '0;
      duty_step  <= '0;
    end else if (start) begin
      freq_timer <= period_of(frequency);
    end else if (enable) begin
      if (freq_timer == '0) begin
        freq_timer <= period_of(freq_shadow);
        duty_step  <= duty_step + 3'd1;
      end else begin
        freq_timer <= freq_timer - TMR_W'(1);
      end
    end
  end

  generate
    if (HAS_SWEEP != 0) begin : g_sweep
      logic [SW1_W-1:0]  sweep_timer;
      logic [SW1_W-1:0]  sweep_reload;
      logic [FREQ_W:0]   shadow_ext;
      logic [FREQ_W:0]   shadow_delta;
      logic [FREQ_W:0]   sweep_sum;
      logic [FREQ_W:0]   trig_sum;
      logic              sweep_fire;

      assign sweep_reload = (sweep_time == '0) ? SW1_W'(2**SWEEP_W) : SW1_W'(sweep_time);
      assign shadow_ext   = {1'b0, freq_shadow};
      assign shadow_delta = {1'b0, freq_shadow >> num_sweep_shifts};
      assign sweep_sum    = sweep_decreasing ? (shadow_ext - shadow_delta)
                                             : (shadow_ext + shadow_delta);
      assign trig_sum     = {1'b0, frequency} + {1'b0, frequency >> num_sweep_shifts};
      assign sweep_fire   = sweep_tick & (sweep_timer <= SW1_W'(1)) & (sweep_time != '0);
      assign sweep_ovf    = sweep_fire & ~sweep_decreasing & sweep_sum[FREQ_W];
      assign trig_ovf     = (num_sweep_shifts != '0) & ~sweep_decreasing & trig_sum[FREQ_W];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sweep_timer <= '0;
          freq_shadow <= '0;
        end else if (start) begin
          sweep_timer <= sweep_reload;
          freq_shadow <= frequency;
        end else if (sweep_tick) begin
          if (sweep_timer <= SW1_W'(1)) begin
            sweep_timer <= sweep_reload;
            if (sweep_fire && !sweep_ovf && (num_sweep_shifts != '0)) begin
              freq_shadow <= sweep_sum[FREQ_W-1:0];
            end
          end else begin
            sweep_timer <= sweep_timer - SW1_W'(1);
          end
        end
      end
    end else begin : g_no_sweep
      assign sweep_ovf = 1'b0;
      assign trig_ovf  = 1'b0;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          freq_shadow <= '0;
        end else begin
          freq_shadow <= frequency;
        end
      end
    end
  endgenerate

  always_comb begin
    enable_nxt = enable;
    if (start) begin
      enable_nxt = dac_on & ~trig_ovf;
    end else if (!dac_on || len_expire || sweep_ovf) begin
      enable_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= 1'b0;
      level  <= '0;
    end else begin
      enable <= enable_nxt;
      level  <= (enable && duty_bit(duty_t'(wave_duty), duty_step)) ? volume : '0;
    end
  end

endmodule

// File: tb/tb_gb_pulse_channel_param.sv
// Directed bench for gb_pulse_channel_param: trigger vector table plus hand-written multi-cycle sequences.
module tb_gb_pulse_channel_param;

  logic        clk;
  logic        reset;
  logic        clk_length_ctr;
  logic        clk_vol_env;
  logic        clk_sweep;
  logic [2:0]  sweep_time;
  logic        sweep_decreasing;
  logic [2:0]  num_sweep_shifts;
  logic [1:0]  wave_duty;
  logic [5:0]  length;
  logic [3:0]  initial_volume;
  logic        envelope_increasing;
  logic [2:0]  num_envelope_sweeps;
  logic        start;
  logic        single;
  logic [10:0] frequency;
  logic [3:0]  level;
  logic        enable;
  logic [10:0] freq_shadow;

  int tests;
  int failed;

  typedef struct {
    logic [3:0]  vol;
    logic        inc;
    logic [1:0]  duty;
    logic [10:0] freq;
    logic        dec;
    logic [2:0]  shift;
    logic [2:0]  stime;
    logic        exp_en;
    logic [3:0]  exp_lvl;
    logic [10:0] exp_shadow;
  } vec_t;

  vec_t vecs[10];

  gb_pulse_channel_param dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_length_ctr      (clk_length_ctr),
    .clk_vol_env         (clk_vol_env),
    .clk_sweep           (clk_sweep),
    .sweep_time          (sweep_time),
    .sweep_decreasing    (sweep_decreasing),
    .num_sweep_shifts    (num_sweep_shifts),
    .wave_duty           (wave_duty),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .start               (start),
    .single              (single),
    .frequency           (frequency),
    .level               (level),
    .enable              (enable),
    .freq_shadow         (freq_shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    clk_length_ctr      = 1'b0;
    clk_vol_env         = 1'b0;
    clk_sweep           = 1'b0;
    sweep_time          = 3'd0;
    sweep_decreasing    = 1'b0;
    num_sweep_shifts    = 3'd0;
    wave_duty           = 2'd2;
    length              = 6'd0;
    initial_volume      = 4'd0;
    envelope_increasing = 1'b0;
    num_envelope_sweeps = 3'd0;
    start               = 1'b0;
    single              = 1'b0;
    frequency           = 11'h000;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic trigger();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // which: 0 = length, 1 = envelope, 2 = sweep
  task automatic pulse(input int which);
    case (which)
      0:       clk_length_ctr = 1'b1;
      1:       clk_vol_env    = 1'b1;
      default: clk_sweep      = 1'b1;
    endcase
    @(negedge clk);
    clk_length_ctr = 1'b0;
    clk_vol_env    = 1'b0;
    clk_sweep      = 1'b0;
  endtask

  initial begin
    logic [3:0] duty_exp [8];
    tests = 0;
    failed = 0;
    clear_inputs();
    reset = 1'b1;

    //                  vol    inc   duty  freq     dec   shift stime  en    lvl    shadow
    vecs[0] = '{4'd7,  1'b0, 2'd2, 11'h000, 1'b0, 3'd0, 3'd0, 1'b1, 4'd7,  11'h000};
    vecs[1] = '{4'd0,  1'b0, 2'd2, 11'h123, 1'b0, 3'd0, 3'd0, 1'b0, 4'd0,  11'h123};
    vecs[2] = '{4'd0,  1'b1, 2'd2, 11'h123, 1'b0, 3'd0, 3'd0, 1'b1, 4'd0,  11'h123};
    vecs[3] = '{4'd15, 1'b0, 2'd2, 11'h700, 1'b0, 3'd1, 3'd1, 1'b0, 4'd0,  11'h700};
    vecs[4] = '{4'd15, 1'b0, 2'd2, 11'h700, 1'b1, 3'd1, 3'd1, 1'b1, 4'd15, 11'h700};
    vecs[5] = '{4'd15, 1'b0, 2'd0, 11'h3FF, 1'b0, 3'd1, 3'd1, 1'b1, 4'd0,  11'h3FF};
    vecs[6] = '{4'd9,  1'b0, 2'd1, 11'h400, 1'b0, 3'd0, 3'd1, 1'b1, 4'd9,  11'h400};
    vecs[7] = '{4'd9,  1'b0, 2'd3, 11'h400, 1'b0, 3'd0, 3'd1, 1'b1, 4'd0,  11'h400};
    vecs[8] = '{4'd9,  1'b0, 2'd2, 11'h7FF, 1'b0, 3'd7, 3'd1, 1'b0, 4'd0,  11'h7FF};
    vecs[9] = '{4'd9,  1'b0, 2'd2, 11'h400, 1'b0, 3'd7, 3'd1, 1'b1, 4'd9,  11'h400};

    #2 reset = 1'b0;
    #1;
    check("reset_enable", 32'(enable), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_shadow", 32'(freq_shadow), 32'd0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      initial_volume      = vecs[i].vol;
      envelope_increasing = vecs[i].inc;
      wave_duty           = vecs[i].duty;
      frequency           = vecs[i].freq;
      sweep_decreasing    = vecs[i].dec;
      num_sweep_shifts    = vecs[i].shift;
      sweep_time          = vecs[i].stime;
      trigger();
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_enable", i), 32'(enable), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_lvl));
      check($sformatf("vec%0d_shadow", i), 32'(freq_shadow), 32'(vecs[i].exp_shadow));
    end

    // Asynchronous reset in the middle of a note.
    do_reset();
    initial_volume = 4'd7;
    trigger();
    repeat (2) @(negedge clk);
    check("t1_level_pre", 32'(level), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("t1_async_enable", 32'(enable), 32'd0);
    check("t1_async_level", 32'(level), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_hold_enable", 32'(enable), 32'd0);
    check("t1_hold_level", 32'(level), 32'd0);
    trigger();
    repeat (2) @(negedge clk);
    check("t1_retrig_enable", 32'(enable), 32'd1);
    check("t1_retrig_level", 32'(level), 32'd7);

    // Length counter: 64-62 = 2 ticks, then single=0 holds forever.
    do_reset();
    initial_volume = 4'd15;
    length = 6'd62;
    single = 1'b1;
    trigger();
    pulse(0);
    check("t2_len_tick1", 32'(enable), 32'd1);
    pulse(0);
    check("t2_len_tick2", 32'(enable), 32'd0);
    single = 1'b0;
    trigger();
    for (int i = 0; i < 100; i++) pulse(0);
    check("t2_len_single0", 32'(enable), 32'd1);

    // Envelope saturation in both directions.
    do_reset();
    initial_volume = 4'd1;
    envelope_increasing = 1'b1;
    num_envelope_sweeps = 3'd1;
    trigger();
    for (int i = 1; i <= 20; i++) begin
      pulse(1);
      @(negedge clk);
      check($sformatf("t3_env_up%0d", i), 32'(level), (i >= 14) ? 32'd15 : 32'(1 + i));
    end
    initial_volume = 4'd15;
    envelope_increasing = 1'b0;
    trigger();
    for (int i = 1; i <= 15; i++) begin
      pulse(1);
      @(negedge clk);
      check($sformatf("t3_env_dn%0d", i), 32'(level), 32'(15 - i));
    end
    check("t3_env_enable", 32'(enable), 32'd1);

    // Duty sequencer at the fastest frequency: one step every 4 clocks.
    do_reset();
    duty_exp = '{4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15};
    frequency = 11'h7FF;
    initial_volume = 4'd15;
    trigger();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_duty_step%0d", k), 32'(level), 32'(duty_exp[k]));
      repeat (4) @(negedge clk);
    end

    // Decreasing sweep moves the shadow frequency.
    do_reset();
    frequency = 11'h7FF;
    sweep_decreasing = 1'b1;
    num_sweep_shifts = 3'd7;
    sweep_time = 3'd1;
    initial_volume = 4'd15;
    trigger();
    check("t5_dec_shadow0", 32'(freq_shadow), 32'h7FF);
    pulse(2);
    check("t5_dec_shadow1", 32'(freq_shadow), 32'h7F0);
    pulse(2);
    check("t5_dec_shadow2", 32'(freq_shadow), 32'h7E1);
    check("t5_dec_enable", 32'(enable), 32'd1);

    // Increasing sweep overflowing mid-note keeps the last shadow value.
    do_reset();
    frequency = 11'h600;
    num_sweep_shifts = 3'd2;
    sweep_time = 3'd1;
    initial_volume = 4'd15;
    trigger();
    check("t5_inc_enable0", 32'(enable), 32'd1);
    pulse(2);
    check("t5_inc_shadow1", 32'(freq_shadow), 32'h780);
    pulse(2);
    check("t5_inc_ovf_enable", 32'(enable), 32'd0);
    check("t5_inc_ovf_shadow", 32'(freq_shadow), 32'h780);

    // Sweep pace 0 leaves the shadow untouched.
    do_reset();
    frequency = 11'h400;
    num_sweep_shifts = 3'd1;
    sweep_time = 3'd0;
    initial_volume = 4'd15;
    trigger();
    for (int i = 0; i < 9; i++) pulse(2);
    check("t5_pace0_shadow", 32'(freq_shadow), 32'h400);

    // Trigger coincident with a length tick: trigger wins and reloads the counter.
    do_reset();
    initial_volume = 4'd15;
    length = 6'd62;
    single = 1'b1;
    trigger();
    pulse(0);
    start = 1'b1;
    clk_length_ctr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clk_length_ctr = 1'b0;
    check("t6_start_wins", 32'(enable), 32'd1);
    pulse(0);
    check("t6_reload_tick1", 32'(enable), 32'd1);
    pulse(0);
    check("t6_reload_tick2", 32'(enable), 32'd0);

    // DAC switched off mid-note.
    do_reset();
    initial_volume = 4'd15;
    trigger();
    check("t6_dac_on", 32'(enable), 32'd1);
    initial_volume = 4'd0;
    @(negedge clk);
    check("t6_dac_off", 32'(enable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
